// File: rtl/shift_deser_pkg.sv
// shift_deser_pkg: shared definitions for the shift_deser8 serial receiver.
//   DIR_*    : shift_direction encodings
//   state_t  : receiver FSM states
//   even_par : even-parity bit over a data word (zero-extended to 32 bits)
package shift_deser_pkg;

  localparam logic [1:0] DIR_IDLE  = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_ABORT = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2
  } state_t;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_par(input logic [31:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/shift_deser_obuf.sv
// shift_deser_obuf: 2-entry synchronous FIFO holding completed words.
// Head entry is a register, so o_dout is stable until a pop.
//   i_clk, i_reset (sync, active low)
//   i_push/i_din : write request; ignored when full unless a pop happens too
//   i_pop        : read request; ignored when empty
//   o_dout       : head word, o_full / o_empty : occupancy flags
module shift_deser_obuf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int CNTW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_head, r_tail;
  logic [CNTW-1:0]  r_cnt;
  logic             w_pop, w_push;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CNTW'(DEPTH));
  assign o_dout  = r_head;

  assign w_pop  = i_pop && !o_empty;
  assign w_push = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (o_empty) r_head <= i_din;
          else         r_tail <= i_din;
          r_cnt <= r_cnt + CNTW'(1);
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - CNTW'(1);
        end
        2'b11: begin
          // Occupancy unchanged; the new word lands behind whatever remains.
          if (r_cnt == CNTW'(1)) begin
            r_head <= i_din;
          end else begin
            r_head <= r_tail;
            r_tail <= i_din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/shift_deser8.sv
// shift_deser8: serial-to-parallel receiver. Collects WIDTH bits LSB-first
// (right shift) or MSB-first (left shift), then pushes the word into a
// 2-entry output buffer read through a valid/ready handshake.
// Optional feature macro: SHIFT_DESER_PARITY_EN adds an even-parity bit
// after each word; mismatching words are dropped and o_parity_err pulses.
//   i_clk, i_reset (sync, active low)
//   i_enable, i_serial_in, i_bit_valid, i_shift_direction : bit input
//   o_data_out, o_data_valid, i_data_ready : output handshake
//   o_busy       : word partially assembled
//   o_overrun    : sticky, a completed word was dropped on a full buffer
//   o_parity_err : one-cycle pulse on parity mismatch (0 without parity)
module shift_deser8
  import shift_deser_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int OBUF_DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_serial_in,
  input  logic             i_bit_valid,
  input  logic [1:0]       i_shift_direction,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_data_valid,
  input  logic             i_data_ready,
  output logic             o_busy,
  output logic             o_overrun,
  output logic             o_parity_err
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sr, w_sr_nxt, w_shifted;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [1:0]       r_dir, w_dir_nxt, w_sh_dir;
  logic             r_overrun, r_perr;
  logic             w_accept, w_abort, w_push, w_perr, w_pop, w_full, w_empty;

  assign w_accept = i_enable && i_bit_valid &&
                    (i_shift_direction == DIR_RIGHT || i_shift_direction == DIR_LEFT);
  assign w_abort  = i_enable && (i_shift_direction == DIR_ABORT);

  // The first bit of a word uses the live direction; the rest use the
  // direction latched with that first bit.
  assign w_sh_dir  = (r_state == IDLE) ? i_shift_direction : r_dir;
  assign w_shifted = (w_sh_dir == DIR_RIGHT) ? {i_serial_in, r_sr[WIDTH-1:1]}
                                             : {r_sr[WIDTH-2:0], i_serial_in};

  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sr_nxt    = r_sr;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_push      = 1'b0;
    w_perr      = 1'b0;
    if (w_abort) begin
      w_state_nxt = IDLE;
      w_sr_nxt    = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_sr_nxt    = w_shifted;
            w_dir_nxt   = i_shift_direction;
            w_cnt_nxt   = CW'(1);
            w_state_nxt = COLLECT;
          end
        end
        COLLECT: begin
          if (w_accept) begin
            w_sr_nxt = w_shifted;
            if (r_cnt == CW'(WIDTH - 1)) begin
              w_cnt_nxt   = '0;
`ifdef SHIFT_DESER_PARITY_EN
              w_state_nxt = PARITY;
`else
              w_push      = 1'b1;
              w_state_nxt = IDLE;
`endif
            end else begin
              w_cnt_nxt = r_cnt + CW'(1);
            end
          end
        end
`ifdef SHIFT_DESER_PARITY_EN
        PARITY: begin
          // The parity bit is checked only; the assembled word stays in r_sr.
          if (w_accept) begin
            w_state_nxt = IDLE;
            if (i_serial_in == even_par(32'(r_sr))) w_push = 1'b1;
            else                                    w_perr = 1'b1;
          end
        end
`endif
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_sr      <= '0;
      r_cnt     <= '0;
      r_dir     <= DIR_IDLE;
      r_overrun <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_sr   <= w_sr_nxt;
      r_cnt  <= w_cnt_nxt;
      r_dir  <= w_dir_nxt;
      r_perr <= w_perr;
      if (w_push && w_full && !w_pop) r_overrun <= 1'b1;
    end
  end

  assign w_pop = !w_empty && i_data_ready;

  // w_sr_nxt is the completed word on the pushing cycle in both builds.
  shift_deser_obuf #(
    .WIDTH (WIDTH),
    .DEPTH (OBUF_DEPTH)
  ) u_obuf (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_din   (w_sr_nxt),
    .i_pop   (w_pop),
    .o_dout  (o_data_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_data_valid = !w_empty;
  assign o_busy       = (r_state != IDLE);
  assign o_overrun    = r_overrun;
`ifdef SHIFT_DESER_PARITY_EN
  assign o_parity_err = r_perr;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_deser8.sv
module tb_shift_deser8;
  localparam logic [1:0] D_IDLE = 2'b00, D_R = 2'b01, D_L = 2'b10, D_AB = 2'b11;
`ifdef SHIFT_DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk = 0, rst_n = 0, en = 0, sin = 0, bv = 0, ready = 0;
  logic [1:0] dir = D_IDLE;
  logic [7:0] dout;
  logic       dvalid, busy, ovr, perr;

  int n_tests = 0, n_fail = 0;

  shift_deser8 #(.WIDTH(8), .OBUF_DEPTH(2)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_enable(en), .i_serial_in(sin),
    .i_bit_valid(bv), .i_shift_direction(dir), .o_data_out(dout),
    .o_data_valid(dvalid), .i_data_ready(ready), .o_busy(busy),
    .o_overrun(ovr), .o_parity_err(perr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic [1:0] d, input logic b);
    en = 1; bv = 1; dir = d; sin = b;
    tick();
    bv = 0; dir = D_IDLE;
  endtask

  task automatic send_data(input logic [1:0] d, input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(d, (d == D_R) ? w[i] : w[7-i]);
  endtask

  task automatic send_word(input logic [1:0] d, input logic [7:0] w);
    send_data(d, w);
    if (PAR_EN) send_bit(d, ^w);
  endtask

  // Reference model: bits kept in arrival order, word built by position.
  bit         m_bits[$];
  logic [7:0] m_oq[$];
  logic [1:0] m_dir;
  logic [7:0] m_pw;
  bit         m_par, m_ovr, m_perr;

  task automatic model_step();
    bit pop, push;
    logic [7:0] w;
    push = 0; w = '0; m_perr = 0;
    if (!rst_n) begin
      m_bits.delete(); m_oq.delete(); m_par = 0; m_ovr = 0;
      return;
    end
    pop = (m_oq.size() > 0) && ready;
    if (en && dir == D_AB) begin
      m_bits.delete(); m_par = 0;
    end else if (en && bv && (dir == D_R || dir == D_L)) begin
      if (m_par) begin
        m_par = 0;
        if (sin == ^m_pw) begin push = 1; w = m_pw; end
        else m_perr = 1;
      end else begin
        if (m_bits.size() == 0) m_dir = dir;
        m_bits.push_back(sin);
        if (m_bits.size() == 8) begin
          for (int i = 0; i < 8; i++)
            if (m_dir == D_R) w[i] = m_bits[i]; else w[7-i] = m_bits[i];
          m_bits.delete();
          if (PAR_EN) begin m_par = 1; m_pw = w; end
          else push = 1;
        end
      end
    end
    if (pop) void'(m_oq.pop_front());
    if (push) begin
      if (m_oq.size() < 2) m_oq.push_back(w);
      else m_ovr = 1;
    end
  endtask

  typedef struct {
    logic [1:0] d;
    logic [7:0] seq;  // arrival order: seq[7] first
    int         sw;   // live direction flips after this many bits (0 = never)
    logic [7:0] exp;
  } vec_t;
  vec_t vecs[6];

  initial begin
    vecs[0] = '{D_R, 8'b10100101, 0, 8'hA5};
    vecs[1] = '{D_L, 8'b00111100, 4, 8'h3C};
    vecs[2] = '{D_R, 8'b11000000, 0, 8'h03};
    vecs[3] = '{D_L, 8'b11000000, 0, 8'hC0};
    vecs[4] = '{D_R, 8'b00000001, 3, 8'h80};
    vecs[5] = '{D_L, 8'b10000000, 0, 8'h80};

    // Reset state
    tick(); tick();
    chk("rst_valid", dvalid, 0); chk("rst_data", dout, 0); chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr, 0);      chk("rst_perr", perr, 0);
    rst_n = 1; ready = 1; en = 1;
    tick();

    // Table vectors
    foreach (vecs[k]) begin
      for (int i = 0; i < 8; i++) begin
        logic [1:0] d;
        d = (vecs[k].sw != 0 && i >= vecs[k].sw) ? ~vecs[k].d : vecs[k].d;
        if (i == 0) chk("vec_idle_busy", busy, 0);
        send_bit(d, vecs[k].seq[7-i]);
      end
      if (PAR_EN) begin
        logic [7:0] e;
        e = vecs[k].exp;
        send_bit(vecs[k].d, ^e);
      end
      chk($sformatf("vec%0d_valid", k), dvalid, 1);
      chk($sformatf("vec%0d_data", k), dout, vecs[k].exp);
      tick();
      chk($sformatf("vec%0d_popped", k), dvalid, 0);
    end

    // Backpressure with overrun
    ready = 0;
    send_word(D_R, 8'h11); send_word(D_R, 8'h22);
    chk("bp_no_ovr", ovr, 0);
    send_word(D_R, 8'h33);
    chk("bp_ovr", ovr, 1); chk("bp_valid", dvalid, 1); chk("bp_head", dout, 8'h11);
    tick();
    chk("bp_hold", dout, 8'h11);
    ready = 1; tick();
    chk("bp_pop2_valid", dvalid, 1); chk("bp_pop2", dout, 8'h22);
    tick();
    chk("bp_empty", dvalid, 0); chk("bp_ovr_sticky", ovr, 1);

    // Abort after 5 bits, then a clean word
    for (int i = 0; i < 5; i++) send_bit(D_R, 1'b1);
    chk("ab_busy", busy, 1);
    en = 1; dir = D_AB; bv = 0; tick(); dir = D_IDLE;
    chk("ab_idle", busy, 0); chk("ab_novalid", dvalid, 0);
    send_word(D_R, 8'h0F);
    chk("ab_valid", dvalid, 1); chk("ab_data", dout, 8'h0F);
    tick();
    chk("ab_only_one", dvalid, 0);

    // enable low holds the partial word, pop still completes
    ready = 0;
    send_word(D_L, 8'h5A);
    for (int i = 0; i < 4; i++) send_bit(D_R, 1'b0 ^ (8'h96 >> i));
    en = 0; ready = 1;
    for (int i = 0; i < 4; i++) begin
      bv = i[0]; dir = D_L; sin = ~i[0]; tick();
    end
    chk("en_pop", dvalid, 0); chk("en_busy", busy, 1);
    bv = 0; dir = D_IDLE;
    for (int i = 4; i < 8; i++) begin
      logic [7:0] w;
      w = 8'h96;
      send_bit(D_R, w[i]);
    end
    if (PAR_EN) send_bit(D_R, ^8'h96);
    chk("en_valid", dvalid, 1); chk("en_data", dout, 8'h96);
    tick();

`ifdef SHIFT_DESER_PARITY_EN
    send_data(D_R, 8'h81); send_bit(D_R, 1'b0);
    chk("par_ok_valid", dvalid, 1); chk("par_ok_data", dout, 8'h81); chk("par_ok_perr", perr, 0);
    tick();
    send_data(D_R, 8'h81); send_bit(D_R, 1'b1);
    chk("par_bad_perr", perr, 1); chk("par_bad_valid", dvalid, 0);
    tick();
    chk("par_pulse_end", perr, 0);
`endif

    // Reset mid-word with a buffered word
    ready = 0;
    send_word(D_R, 8'h42);
    for (int i = 0; i < 3; i++) send_bit(D_R, 1'b1);
    chk("mr_busy", busy, 1); chk("mr_valid", dvalid, 1);
    rst_n = 0; tick();
    chk("mr_busy0", busy, 0); chk("mr_valid0", dvalid, 0); chk("mr_ovr0", ovr, 0);
    rst_n = 1;

    // Randomized run against the model
    rst_n = 0; tick(); model_step();
    for (int c = 0; c < 1500; c++) begin
      int r;
      rst_n = ($urandom_range(0, 299) != 0);
      en    = ($urandom_range(0, 9) != 0);
      bv    = ($urandom_range(0, 4) != 0);
      r     = $urandom_range(0, 39);
      dir   = (r == 0) ? D_AB : (r == 1) ? D_IDLE : (r < 21) ? D_R : D_L;
      sin   = 1'($urandom_range(0, 1));
      ready = ($urandom_range(0, 9) < 6);
      tick();
      model_step();
      chk("rnd_valid", dvalid, m_oq.size() > 0);
      if (m_oq.size() > 0) chk("rnd_data", dout, m_oq[0]);
      chk("rnd_busy", busy, (m_bits.size() > 0) || m_par);
      chk("rnd_ovr", ovr, m_ovr);
      chk("rnd_perr", perr, m_perr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_deser8.md
# shift_deser8

Serial-to-parallel receiver paired with the team's parallel-load shift register. It collects a stream of single bits, shifting them right (LSB-first) or left (MSB-first), and assembles WIDTH-bit words. Each completed word is presented through a valid/ready handshake, backed by a 2-entry output buffer. It sits at the receive end of the serial links fed by the shift-register transmitters.

## Interface
- WIDTH, 8, data word width in bits; legal range 2..32.
- OBUF_DEPTH, 2, output buffer entries; fixed at 2 in this revision.

- clk  input  1  rising-edge clock, single domain.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  global sample enable; when low, no bit is accepted and state is held.
- serial_in  input  1  incoming data bit.
- bit_valid  input  1  serial_in is meaningful this cycle.
- shift_direction  input  2  encodings:
  - 00: idle / ignore.
  - 01: right shift, LSB-first; the bit enters at the MSB.
  - 10: left shift, MSB-first; the bit enters at the LSB.
  - 11: abort the current word.
- data_out  output  WIDTH  head word of the output buffer.
- data_valid  output  1  data_out holds a word.
- data_ready  input  1  consumer accepts; a pop happens when data_valid && data_ready.
- busy  output  1  a word is partially assembled (bit count > 0).
- overrun  output  1  sticky; a completed word was dropped because the buffer was full. Cleared only by reset.
- parity_err  output  1  pulses one cycle on a parity mismatch; tied 0 when parity is compiled out.

## Operation
- Bit accept condition: accept = enable && bit_valid && (shift_direction is 01 or 10).
- State machine, states IDLE, COLLECT, PARITY.
  - IDLE → COLLECT: on accept. The first bit latches the word direction into dir_q.
  - COLLECT, accept: shift using dir_q, not the live input. A changed live direction mid-word is ignored except for 11.
  - COLLECT: bit counter runs 0..WIDTH-1. Accepting the WIDTH-th bit completes the word. The next state is PARITY if parity is enabled, otherwise IDLE with a push.
  - PARITY: the next accepted bit is checked against even parity of the word. On match, push and go to IDLE. On mismatch, drop the word, pulse parity_err, and go to IDLE.
  - shift_direction == 11 with enable high, in any state: clear the shift register and counter and go to IDLE. No push; buffer contents are unaffected.
- Push into the buffer:
  - Buffer not full: the word is written.
  - Buffer full with a pop the same cycle: the word is written (simultaneous push and pop is legal).
  - Buffer full with no pop: the word is dropped and overrun is set.
- Right shift: sr <= {serial_in, sr[WIDTH-1:1]}. Left shift: sr <= {sr[WIDTH-2:0], serial_in}.
- Pop happens independently of enable.

## Timing
- Reset values: data_out=0, data_valid=0, busy=0, overrun=0, parity_err=0. State is IDLE, the counter is 0, and the buffer is empty.
- Latency: data_valid rises the cycle after the final data bit is accepted, or after the parity bit when parity is enabled.
- Throughput: one bit per cycle. Back-to-back words are possible; the first bit of the next word may arrive the cycle after the completing bit.
- data_out and data_valid are registered and stable while data_valid && !data_ready.
- Reset asserted mid-word or with a full buffer: everything clears on that edge. Partial and buffered words are lost.

## Configuration
- SHIFT_DESER_PARITY_EN defined: the PARITY state exists; one extra bit per word (even parity over the data bits); parity_err is driven.
- Not defined: there is no PARITY state; a word completes after WIDTH bits; parity_err is constant 0. The port list is identical in both builds.

## Structure
- Package shift_deser_pkg contains:
  - localparams for the shift_direction encodings (DIR_IDLE, DIR_RIGHT, DIR_LEFT, DIR_ABORT);
  - the state enum (IDLE, COLLECT, PARITY);
  - a parity function.
- Sub-module shift_deser_obuf: a 2-entry synchronous FIFO with push, pop, full and empty flags and registered head output. The top level holds the FSM, shift register, counter and overrun logic.

## Test plan
- LSB-first 0xA5: dir=01, bits 1,0,1,0,0,1,0,1 on consecutive cycles with data_ready=1 → data_out=0xA5 with data_valid high one cycle after the 8th bit.
- MSB-first 0x3C: dir=10, bits 0,0,1,1,1,1,0,0, with dir switched to 01 after bit 4 → data_out=0x3C (dir_q is held for the word).
- Backpressure: data_ready=0, three words 0x11, 0x22, 0x33 → buffer holds 0x11 then 0x22; overrun=1; after raising data_ready, pops are 0x11 then 0x22 and 0x33 is lost.
- Abort and reset: dir=11 after 5 bits, then word 0x0F → only 0x0F is output. Reset low mid-word → busy=0 and data_valid=0 next cycle.
- Parity build: 0x81 followed by parity bit 0 → accepted. 0x81 followed by parity bit 1 → parity_err pulses and no data_valid.
- enable=0 with bit_valid toggling → counter and sr unchanged; a pending pop still completes.
